// File: rtl/pc_next_if.sv
// Decode-to-fetch redirect bundle and PC outputs of the next-PC unit.
// Decode drives through master; the PC unit sits on slave.
interface pc_next_if #(
   parameter int Data_width = 32
);
   logic                  stall;
   logic                  branch_taken;
   logic [Data_width-1:0] branch_offset_sh;
   logic [Data_width-1:0] branch_base;
   logic                  jump;
   logic [25:0]           jump_index;
   logic [Data_width-1:0] pc;
   logic [Data_width-1:0] pc_plus4;
   logic                  flush;
   logic                  misaligned;

   modport master (
      output stall, branch_taken, branch_offset_sh,
      output branch_base, jump, jump_index,
      input  pc, pc_plus4, flush, misaligned
   );

   modport slave (
      input  stall, branch_taken, branch_offset_sh,
      input  branch_base, jump, jump_index,
      output pc, pc_plus4, flush, misaligned
   );
endinterface

// File: rtl/pc_next_unit.sv
// Fetch PC register with branch/jump redirect; a redirect seen under
// stall is parked and loaded once the stall releases.
module pc_next_unit #(
   parameter int                    Data_width = 32,
   parameter logic [Data_width-1:0] RESET_PC   = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   pc_next_if.slave      bus
);
   typedef enum logic {RUN, PEND} state_e;

   localparam logic [Data_width-1:0] FOUR = Data_width'(4);

   state_e                state_q, state_d;
   logic [Data_width-1:0] pc_q, pc_d;
   logic [Data_width-1:0] pend_addr_q, pend_addr_d;
   logic                  flush_q, flush_d;

   logic [Data_width-1:0] br_tgt;
   logic [Data_width-1:0] jmp_tgt;
   logic [Data_width-1:0] tgt;
   logic                  redirect;

   always_comb begin
      br_tgt        = bus.branch_base + bus.branch_offset_sh;
      // upper nibble of PC+4 kept, low 28 bits from the index
      jmp_tgt       = bus.branch_base;
      jmp_tgt[27:0] = {bus.jump_index, 2'b00};
      tgt           = bus.branch_taken ? br_tgt : jmp_tgt;
      redirect      = bus.branch_taken | bus.jump;
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_addr_d = pend_addr_q;
      flush_d     = 1'b0;
      unique case (state_q)
         RUN: begin
            if (!bus.stall) begin
               pc_d    = redirect ? tgt : pc_q + FOUR;
               flush_d = redirect;
            end else if (redirect) begin
               pend_addr_d = tgt;
               state_d     = PEND;
            end
         end
         PEND: begin
            if (!bus.stall) begin
               pc_d    = pend_addr_q;
               flush_d = 1'b1;
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         pc_q        <= RESET_PC;
         pend_addr_q <= '0;
         flush_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_addr_q <= pend_addr_d;
         flush_q     <= flush_d;
      end
   end

   assign bus.pc         = pc_q;
   assign bus.pc_plus4   = pc_q + FOUR;
   assign bus.flush      = flush_q;
   assign bus.misaligned = |pc_q[1:0];
endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 Parameter Data_width, default 32: width of PC, offset and base paths.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  hazard stall from decode; PC holds while high.
REQ-006 branch_taken  input  1  decode resolved a taken conditional branch this cycle.
REQ-007 branch_offset_sh  input  Data_width  sign-extended branch immediate already shifted left by 2 (word-to-byte offset).
REQ-008 branch_base  input  Data_width  PC+4 of the branch/jump instruction in decode.
REQ-009 jump  input  1  decode holds an unconditional J/JAL this cycle.
REQ-010 jump_index  input  26  instr_index field of the jump.
REQ-011 pc  output  Data_width  current fetch address (registered).
REQ-012 pc_plus4  output  Data_width  pc + 4, combinational from pc.
REQ-013 flush  output  1  registered; high for exactly one cycle when a redirect is loaded into pc.
REQ-014 misaligned  output  1  high when pc[1:0] != 2'b00.

Function
REQ-015 Branch target SHALL be branch_base + branch_offset_sh, modulo 2^Data_width (wrap, no overflow flag).
REQ-016 Jump target SHALL be {branch_base[31:28], jump_index, 2'b00}.
REQ-017 Redirect request SHALL be branch_taken OR jump; if both are high, the branch target SHALL win.
REQ-018 States: RUN, PEND. Pending register pend_addr (Data_width) is valid only in PEND.
REQ-019 RUN, stall=0, redirect: pc <= target, flush <= 1, stay RUN.
REQ-020 RUN, stall=0, no redirect: pc <= pc + 4 (wraps at 2^Data_width), flush <= 0.
REQ-021 RUN, stall=1, redirect: pc held, pend_addr <= target, go PEND, flush <= 0.
REQ-022 RUN, stall=1, no redirect: pc held, flush <= 0.
REQ-023 PEND, stall=1: pc held, pend_addr held; new redirect requests are ignored.
REQ-024 PEND, stall=0: pc <= pend_addr, flush <= 1, go RUN; any redirect input in this cycle is ignored.
REQ-025 flush SHALL never be high in two consecutive cycles unless two redirects are loaded back-to-back in RUN with stall=0.
REQ-026 misaligned is purely informational; pc SHALL NOT be masked or corrected.
REQ-027 Latency: redirect presented in cycle N (stall=0) appears on pc and flush after edge N+1.

Reset
REQ-028 While rst_n=0: pc=RESET_PC, state=RUN, pend_addr=0, flush=0, regardless of clk.
REQ-029 Reset asserted mid-PEND SHALL discard the pending redirect; first fetch after release is RESET_PC, then RESET_PC+4.
REQ-030 First pc update SHALL occur on the first rising clk edge with rst_n=1.

Verification
REQ-031 Sequential fetch: reset release, stall=0, no redirect, 4 cycles -> pc 0x0,0x4,0x8,0xC,0x10; flush=0.
REQ-032 Branch: branch_base=0x104, branch_offset_sh=0xFFFF_FFF0, branch_taken=1 one cycle -> next pc=0xF4, flush=1 one cycle, then pc=0xF8.
REQ-033 Jump with branch priority: jump=1, jump_index=0x0000040, branch_base=0x4000_0010, branch_taken=0 -> pc=0x4000_0100; repeat with branch_taken=1, offset=0x8 -> pc=0x4000_0018.
REQ-034 Stalled redirect: stall=1, branch target 0x200 one cycle, stall held 3 cycles with jump to 0x300 during stall -> pc held, then pc=0x200 with flush=1 on the cycle after stall drops; 0x300 never loaded.
REQ-035 Wrap: pc=0xFFFF_FFFC, no redirect -> pc=0x0; branch_base=0xFFFF_FFF0, offset=0x20 -> pc=0x10.
REQ-036 Reset mid-PEND: enter PEND with target 0x80, assert rst_n=0 asynchronously between edges -> pc=RESET_PC immediately, flush=0, after release pc advances from RESET_PC, 0x80 never appears.
